aximm_scratch_ram: RTL and testbench

AXIMM_SCRATCH_RAM -- requirements
Module: aximm_scratch_ram

---
 rtl/aximm_scratch_ram.sv | 128 ++++++++++++
 tb/tb_aximm_scratch_ram.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aximm_scratch_ram.sv
// aximm_scratch_ram: single-beat 128-bit AXI-MM scratch RAM with strobed writes and a 3-state read path.
// Define AXIMM_SCRATCH_ADDR_CHECK_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module aximm_scratch_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        aximm_awid,
    input  logic [ADDR_W-1:0] aximm_awaddr,
    input  logic              aximm_awvalid,
    output logic              aximm_awready,
    input  logic [127:0]      aximm_wdata,
    input  logic [15:0]       aximm_wstrb,
    input  logic              aximm_wvalid,
    input  logic              aximm_wlast,
    output logic              aximm_wready,
    output logic [7:0]        aximm_bid,
    output logic [1:0]        aximm_bresp,
    output logic              aximm_bvalid,
    input  logic              aximm_bready,
    input  logic [7:0]        aximm_arid,
    input  logic [ADDR_W-1:0] aximm_araddr,
    input  logic              aximm_arvalid,
    output logic              aximm_arready,
    output logic [7:0]        aximm_rid,
    output logic [127:0]      aximm_rdata,
    output logic [1:0]        aximm_rresp,
    output logic              aximm_rlast,
    output logic              aximm_rvalid,
    input  logic              aximm_rready
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] R_IDLE = 2'd0, R_LAT = 2'd1, R_RESP = 2'd2;

    logic [127:0]  mem [DEPTH];
    logic          rdy_en, aw_full, w_full, aw_oor, ar_oor, aw_bad, ar_bad, commit;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [7:0]    aw_id;
    logic [127:0]  w_data;
    logic [15:0]   w_strb;
    logic [1:0]    r_state;
    logic          unused;

`ifdef AXIMM_SCRATCH_ADDR_CHECK_EN
    assign aw_bad = (aximm_awaddr >> (IW + 4)) != '0;
    assign ar_bad = (aximm_araddr >> (IW + 4)) != '0;
`else
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
`endif

    assign unused        = &{1'b0, aximm_wlast, aximm_awaddr, aximm_araddr};
    assign commit        = aw_full && w_full;
    // rdy_en keeps every ready low until the first edge after reset releases
    assign aximm_awready = rdy_en && !aw_full && !aximm_bvalid;
    assign aximm_wready  = rdy_en && !w_full && !aximm_bvalid;
    assign aximm_arready = rdy_en && r_state == R_IDLE;
    assign aximm_rvalid  = r_state == R_RESP;
    assign aximm_rlast   = aximm_rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_en       <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_oor       <= 1'b0;
            aw_idx       <= '0;
            aw_id        <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            aximm_bvalid <= 1'b0;
            aximm_bid    <= '0;
            aximm_bresp  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (aximm_awvalid && aximm_awready) begin
                aw_full <= 1'b1;
                aw_id   <= aximm_awid;
                aw_idx  <= aximm_awaddr[IW+3:4];
                aw_oor  <= aw_bad;
            end
            if (aximm_wvalid && aximm_wready) begin
                w_full <= 1'b1;
                w_data <= aximm_wdata;
                w_strb <= aximm_wstrb;
            end
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                aximm_bvalid <= 1'b1;
                aximm_bid    <= aw_id;
                aximm_bresp  <= aw_oor ? 2'b10 : 2'b00;
            end else if (aximm_bvalid && aximm_bready) begin
                aximm_bvalid <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; a commit abandoned by reset never lands
    always_ff @(posedge clk) begin
        if (!reset && commit && !aw_oor)
            for (int i = 0; i < 16; i++)
                if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= R_IDLE;
            ar_idx      <= '0;
            ar_oor      <= 1'b0;
            aximm_rid   <= '0;
            aximm_rdata <= '0;
            aximm_rresp <= '0;
        end else if (r_state == R_IDLE && aximm_arvalid) begin
            r_state   <= R_LAT;
            aximm_rid <= aximm_arid;
            ar_idx    <= aximm_araddr[IW+3:4];
            ar_oor    <= ar_bad;
        end else if (r_state == R_LAT) begin
            r_state     <= R_RESP;
            aximm_rdata <= ar_oor ? '0 : mem[ar_idx];
            aximm_rresp <= ar_oor ? 2'b10 : 2'b00;
        end else if (r_state == R_RESP && aximm_rready) begin
            r_state <= R_IDLE;
        end
    end
endmodule

// File: tb/tb_aximm_scratch_ram.sv
// tb_aximm_scratch_ram: directed and randomized checks of aximm_scratch_ram against a word-array model.
module tb_aximm_scratch_ram;
    localparam int DEPTH = 256;
    localparam int IW    = $clog2(DEPTH);

    logic         clk = 1'b0, reset;
    logic [7:0]   awid, bid, arid, rid;
    logic [31:0]  awaddr, araddr;
    logic         awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic [1:0]   bresp, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    int n_tests = 0, n_fail = 0;
    logic [127:0] model [DEPTH];

    aximm_scratch_ram #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .aximm_awid(awid), .aximm_awaddr(awaddr), .aximm_awvalid(awvalid), .aximm_awready(awready),
        .aximm_wdata(wdata), .aximm_wstrb(wstrb), .aximm_wvalid(wvalid), .aximm_wlast(wlast),
        .aximm_wready(wready), .aximm_bid(bid), .aximm_bresp(bresp), .aximm_bvalid(bvalid),
        .aximm_bready(bready), .aximm_arid(arid), .aximm_araddr(araddr), .aximm_arvalid(arvalid),
        .aximm_arready(arready), .aximm_rid(rid), .aximm_rdata(rdata), .aximm_rresp(rresp),
        .aximm_rlast(rlast), .aximm_rvalid(rvalid), .aximm_rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] data,
                                           input logic [15:0] strb);
        merge = old;
        for (int i = 0; i < 16; i++) if (strb[i]) merge[8*i +: 8] = data[8*i +: 8];
    endfunction

    function automatic bit out_of_range(input logic [31:0] addr);
`ifdef AXIMM_SCRATCH_ADDR_CHECK_EN
        return (addr >> (IW + 4)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // mode 0: AW and W together, 1: W first, 2: AW first; gap = idle cycles before the second channel
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] id, input logic [127:0] data,
                             input logic [15:0] strb, input int mode, input int gap, input int bdelay,
                             output logic [1:0] resp, output logic [7:0] id_o);
        bit aw_p = 1, w_p = 1, a, w;
        int t = 0;
        awaddr = addr; awid = id; wdata = data; wstrb = strb; wlast = 1'b1; bready = 1'b0;
        awvalid = (mode != 1); wvalid = (mode != 2);
        while ((aw_p || w_p) && t < 200) begin
            a = awvalid && awready;
            w = wvalid && wready;
            tick; t++;
            if (a) begin awvalid = 0; aw_p = 0; end
            if (w) begin wvalid = 0; w_p = 0; end
            if ((aw_p && !awvalid) || (w_p && !wvalid)) begin
                for (int g = 0; g < gap; g++) begin
                    check(aw_p ? "wready low while W slot full" : "awready low while AW slot full",
                          aw_p ? wready : awready, 0);
                    tick;
                end
                awvalid = aw_p; wvalid = w_p;
            end
        end
        check("write handshake pending", aw_p || w_p, 0);
        check("bvalid before commit", bvalid, 0);
        tick;
        check("bvalid one edge after slots full", bvalid, 1);
        for (int d = 0; d < bdelay; d++) begin
            tick;
            check("bvalid held", bvalid, 1);
            check("awready low while bvalid", awready, 0);
        end
        resp = bresp; id_o = bid;
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("bvalid after bready", bvalid, 0);
        check("readies after B", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] id, input int stall,
                            output logic [127:0] data, output logic [7:0] id_o, output logic [1:0] resp);
        int t = 0;
        araddr = addr; arid = id; arvalid = 1'b1; rready = 1'b0;
        while (!arready && t < 50) begin tick; t++; end
        check("arready wait", arready, 1);
        tick;
        arvalid = 1'b0;
        check("rvalid in latency cycle", rvalid, 0);
        check("arready busy", arready, 0);
        tick;
        check("rvalid 2 cycles after AR", rvalid, 1);
        check("rlast equals rvalid", rlast, 1);
        data = rdata; id_o = rid; resp = rresp;
        for (int s = 0; s < stall; s++) begin
            tick;
            check("rvalid held", rvalid, 1);
            check("rdata stable", rdata, data);
            check("rid stable", rid, id_o);
            check("arready low while R pending", arready, 0);
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("rvalid after rready", rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] id, input logic [127:0] data,
                      input logic [15:0] strb, input int mode, input int gap, input int bdelay);
        logic [1:0] r;
        logic [7:0] i;
        axi_write(addr, id, data, strb, mode, gap, bdelay, r, i);
        check("bid", i, id);
        check("bresp", r, out_of_range(addr) ? 2'b10 : 2'b00);
        if (!out_of_range(addr)) model[addr[IW+3:4]] = merge(model[addr[IW+3:4]], data, strb);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [7:0] id, input int stall);
        logic [127:0] d;
        logic [7:0]   i;
        logic [1:0]   r;
        axi_read(addr, id, stall, d, i, r);
        check("rid", i, id);
        check("rresp", r, out_of_range(addr) ? 2'b10 : 2'b00);
        check("rdata", d, out_of_range(addr) ? 128'h0 : model[addr[IW+3:4]]);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d;
        logic [31:0]  a;
        reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awid = 0; awaddr = 0; wdata = 0; wstrb = 0; wlast = 0; arid = 0; araddr = 0;
        repeat (3) tick;
        check("reset readies", {awready, wready, arready}, 3'b000);
        check("reset valids", {bvalid, rvalid, rlast}, 3'b000);
        check("reset resp/id", {bresp, rresp, bid, rid}, 20'h0);
        check("reset rdata", rdata, 128'h0);
        reset = 0;
        check("readies low before first edge", awready, 0);
        tick;
        check("readies after reset", {awready, wready, arready}, 3'b111);

        for (int w = 0; w < 16; w++) wr(w << 4, 8'(w), rnd128(), 16'hFFFF, 0, 0, 0);

        d = rnd128(); d[31:0] = 32'h44332211;
        wr(32'h10, 8'h80, d, 16'h000F, 0, 0, 0);
        rd(32'h10, 8'h81, 0);

        wr(32'h40, 8'h11, rnd128(), 16'hFFFF, 1, 3, 0);
        repeat (3) begin tick; check("single B response", bvalid, 0); end
        rd(32'h40, 8'h12, 0);
        wr(32'h50, 8'h13, rnd128(), 16'h5A5A, 2, 2, 2);
        rd(32'h50, 8'h14, 1);

        wr(32'h20, 8'h21, {16{8'hFF}}, 16'hFFFF, 0, 0, 0);
        wr(32'h20, 8'h22, 128'h0, 16'h00F0, 0, 0, 0);
        rd(32'h20, 8'h23, 0);
        check("strobe merge literal", model[2], {{8{8'hFF}}, 32'h0, 32'hFFFFFFFF});

        rd(32'h30, 8'h31, 5);

        wr(32'h0000_1000, 8'h41, rnd128(), 16'hFFFF, 0, 0, 0);
        rd(32'h0000_1000, 8'h42, 0);
        rd(32'h0, 8'h43, 0);

        // abandon a half-filled write with reset
        awaddr = 32'h50; awid = 8'h51; awvalid = 1;
        check("awready before abandon", awready, 1);
        tick;
        awvalid = 0;
        reset = 1; tick; reset = 0; tick;
        wr(32'h60, 8'h52, rnd128(), 16'hFFFF, 0, 0, 0);
        rd(32'h50, 8'h53, 0);
        rd(32'h60, 8'h54, 0);

        // reset while bvalid is high
        d = rnd128();
        awaddr = 32'h70; awid = 8'h61; wdata = d; wstrb = 16'hFFFF; bready = 0;
        awvalid = 1; wvalid = 1;
        check("readies before bvalid reset", {awready, wready}, 2'b11);
        tick;
        awvalid = 0; wvalid = 0;
        tick;
        check("bvalid before reset", bvalid, 1);
        model[7] = d;
        reset = 1; tick;
        check("bvalid cleared by reset", bvalid, 0);
        check("readies in reset", {awready, wready, arready}, 3'b000);
        reset = 0; tick;
        check("readies after reset release", {awready, wready, arready}, 3'b111);
        repeat (3) begin tick; check("no B after reset", bvalid, 0); end
        rd(32'h70, 8'h62, 0);

        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
`ifndef AXIMM_SCRATCH_ADDR_CHECK_EN
            a = a | ($urandom_range(0, 15) << (IW + 4));
`endif
            if ($urandom_range(0, 1) == 1)
                wr(a, 8'($urandom), rnd128(), 16'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 2));
            else
                rd(a, 8'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
